adder_rr_sched: RTL and testbench
=================================

Name: adder_rr_sched

Overview:
- Round-robin scheduler that shares one single-cycle-latency W-bit adder (start/a/b in, y/valid out) among N requesters.
- Accepts an operand pair per requester via valid/ready and drives the adder's start pulse.
- Captures the adder result and returns it with the winner's ID over a valid/ready response channel.
- Sits between N client engines and the shared adder instance.

Parameters:
- W, 20, operand/result width
- N, 4, number of requesters (2..16)
- IDW, $clog2(N) (min 1), requester ID width
- TIMEOUT_CYC, 8, max cycles in WAIT before error; used only with the optional feature

Ports:
- clk  in  1  clock, all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  N  per-requester operand valid
- req_ready  out  N  per-requester accept; one-hot or zero
- req_a  in  N*W  packed operands A, requester i at [i*W +: W]
- req_b  in  N*W  packed operands B
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  IDW  requester that owns the response
- rsp_y  out  W  result (a+b mod 2^W)
- rsp_err  out  1  response is a timeout error
- add_start  out  1  adder start pulse
- add_a  out  W  adder operand A
- add_b  out  W  adder operand B
- add_y  in  W  adder result
- add_valid  in  1  adder result valid

Behaviour:
- Reset (async, any state): FSM=IDLE; req_ready=0, rsp_valid=0, rsp_id=0, rsp_y=0, rsp_err=0, add_start=0, add_a=0, add_b=0; rr pointer=N-1, so requester 0 has top priority first.
- FSM states IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Winner = first requester with req_valid set, searching from (ptr+1) mod N upward with wrap.
  - req_ready[winner]=1 combinationally in that cycle; handshake completes in that cycle.
  - Register winner ID, req_a/req_b slices into add_a/add_b -> ISSUE.
  - No req_valid -> stay in IDLE, req_ready=0.
- ISSUE: add_start=1 for exactly one cycle; add_a/add_b held stable from ISSUE through the end of WAIT -> WAIT.
- WAIT:
  - add_start=0.
  - On add_valid=1: register rsp_y<=add_y, rsp_err<=0 -> RESP.
  - add_valid outside WAIT is ignored.
- RESP:
  - rsp_valid=1; rsp_id/rsp_y/rsp_err held stable until rsp_ready.
  - On rsp_ready=1: ptr<=rsp_id -> IDLE with rsp_valid=0.
  - No new request is accepted while in RESP.
- Nominal occupancy: 4 cycles per op with the 1-cycle adder and rsp_ready tied high.
- Back-to-back: a requester that keeps req_valid high yields to any other valid requester (strict rotation). A lone requester is re-granted every op.
- Requester dropping req_valid before grant is legal; no state retained.
- At most one op in flight; req_ready is never asserted outside IDLE.

Optional Feature:
- Macro ADDER_SCHED_TIMEOUT_EN.
- Defined:
  - A WAIT cycle counter resets on entry to WAIT.
  - If TIMEOUT_CYC cycles pass in WAIT without add_valid: rsp_y<=0, rsp_err<=1 -> RESP.
  - add_valid in the same cycle the count expires wins (normal result, err=0).
- Undefined: no counter; WAIT holds indefinitely; rsp_err is constant 0.

Decomposition:
- Package adder_sched_pkg: state enum (IDLE, ISSUE, WAIT, RESP), default W/N constants, IDW helper function.
- Sub-module rr_pick (combinational): inputs req vector and ptr; outputs one-hot grant, grant index, any-valid.

Test Plan:
- Single op: reset, then req_valid[2]=1, a=100, b=23 -> req_ready[2] in IDLE cycle; add_start 1 cycle later; rsp_valid with rsp_id=2, rsp_y=123, rsp_err=0 exactly 3 cycles after the handshake.
- Round-robin: all 4 requesters valid constantly, rsp_ready=1 -> grants in order 0,1,2,3,0; each rsp_y matches its requester's a+b.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_y/rsp_id stable, all req_ready=0; release -> return to IDLE, next grant rotates.
- Wrap: a=2^20-1, b=2 -> rsp_y=1, rsp_err=0.
- Reset mid-op: assert rst_n=0 during WAIT -> all outputs 0 immediately; after release, requester 0 wins over 3 when both are valid.
- Timeout (macro defined): adder never asserts add_valid -> rsp_valid with rsp_err=1, rsp_y=0 after 8 WAIT cycles. Macro undefined: FSM stays in WAIT with rsp_valid=0.

Source files
------------

// File: rtl/adder_sched_pkg.sv
// Shared types and defaults for the round-robin adder scheduler.
package adder_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sched_state_e;

    localparam int DEF_W = 20;
    localparam int DEF_N = 4;

    // Requester ID width; a single-bit ID is kept even for N <= 2.
    function automatic int idw_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/adder_rr_sched_rr_pick.sv
// Combinational round-robin picker: first set request after ptr, with wrap.
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] idx,
    output logic           any
);

    int             cand;
    logic [IDW-1:0] cand_idx;

    always_comb begin
        grant    = '0;
        idx      = '0;
        any      = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 1; k <= N; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N) cand = cand - N;
            cand_idx = IDW'(cand);
            if (!any && req[cand_idx]) begin
                any             = 1'b1;
                grant[cand_idx] = 1'b1;
                idx             = cand_idx;
            end
        end
    end

endmodule

// File: rtl/adder_rr_sched.sv
// Round-robin scheduler sharing one single-cycle adder among N requesters.
// Optional WAIT timeout enabled by defining ADDER_SCHED_TIMEOUT_EN.
//
// state | meaning
// IDLE  | pick winner, accept its operands
// ISSUE | pulse add_start with held operands
// WAIT  | wait for add_valid (or timeout)
// RESP  | present result until rsp_ready
module adder_rr_sched
    import adder_sched_pkg::*;
#(
    parameter int W           = DEF_W,
    parameter int N           = DEF_N,
    parameter int IDW         = idw_of(N),
    parameter int TIMEOUT_CYC = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req_valid,
    output logic [N-1:0]   req_ready,
    input  logic [N*W-1:0] req_a,
    input  logic [N*W-1:0] req_b,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [IDW-1:0] rsp_id,
    output logic [W-1:0]   rsp_y,
    output logic           rsp_err,
    output logic           add_start,
    output logic [W-1:0]   add_a,
    output logic [W-1:0]   add_b,
    input  logic [W-1:0]   add_y,
    input  logic           add_valid
);

    sched_state_e   state, state_nxt;
    logic [IDW-1:0] ptr;
    logic [N-1:0]   grant;
    logic [IDW-1:0] grant_idx;
    logic           grant_any;
    logic [W-1:0]   sel_a, sel_b;
    logic           wait_expired;

    rr_pick #(.N(N), .IDW(IDW)) u_pick (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                sel_a = req_a[i*W +: W];
                sel_b = req_b[i*W +: W];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        add_start = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                // Gated by rst_n so no handshake is offered while reset holds the FSM.
                if (rst_n) req_ready = grant;
                if (grant_any) state_nxt = ISSUE;
            end
            ISSUE: begin
                add_start = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (add_valid || wait_expired) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ptr    <= IDW'(N - 1);
            rsp_id <= '0;
            rsp_y  <= '0;
            add_a  <= '0;
            add_b  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        rsp_id <= grant_idx;
                        add_a  <= sel_a;
                        add_b  <= sel_b;
                    end
                end
                WAIT: begin
                    if (add_valid)         rsp_y <= add_y;
                    else if (wait_expired) rsp_y <= '0;
                end
                RESP: begin
                    if (rsp_ready) ptr <= rsp_id;
                end
                default: ;
            endcase
        end
    end

`ifdef ADDER_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] wait_cnt;

    assign wait_expired = (state == WAIT) && (wait_cnt == '0);

    // Loaded in ISSUE so the count starts fresh on every WAIT entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            rsp_err  <= 1'b0;
        end else begin
            if (state == ISSUE) begin
                wait_cnt <= TW'(TIMEOUT_CYC - 1);
            end else if (state == WAIT && wait_cnt != '0) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
            if (state == WAIT) begin
                if (add_valid)         rsp_err <= 1'b0;
                else if (wait_expired) rsp_err <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT_CYC > 0);
    assign wait_expired   = 1'b0;
    assign rsp_err        = 1'b0;
`endif

endmodule

// File: tb/tb_adder_rr_sched.sv
// Self-checking bench for adder_rr_sched: transaction-level model plus directed literal checks.
module tb_adder_rr_sched;

    localparam int W   = 20;
    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int TO  = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a, req_b;
    logic           rsp_valid, rsp_ready;
    logic [IDW-1:0] rsp_id;
    logic [W-1:0]   rsp_y;
    logic           rsp_err;
    logic           add_start;
    logic [W-1:0]   add_a, add_b, add_y;
    logic           add_valid;

    always #5 clk = ~clk;

    adder_rr_sched #(.W(W), .N(N), .IDW(IDW), .TIMEOUT_CYC(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_y     (rsp_y),
        .rsp_err   (rsp_err),
        .add_start (add_start),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_y     (add_y),
        .add_valid (add_valid)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model of one operation: cycles elapsed since its handshake, and who/what it carries.
    bit           m_busy;
    int           m_age, m_id, m_last, m_delay;
    logic [W-1:0] m_a, m_b;
    int           hs_cyc, rsp_cyc;
    logic [W-1:0] last_y;
    int           last_id;
    logic         last_err;
    int           grants_q[$];

    logic [N-1:0] stim_valid;
    logic [W-1:0] stim_a[N];
    logic [W-1:0] stim_b[N];
    bit           stim_rdy;
    int           cur_delay;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int model_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++)
            if (v[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    // Adder answers 'd' cycles after start; cycle index counted from the handshake.
    function automatic int rsp_start(input int d);
`ifdef ADDER_SCHED_TIMEOUT_EN
        return (d <= TO) ? 2 + d : 2 + TO;
`else
        return 2 + d;
`endif
    endfunction

    function automatic bit exp_err(input int d);
`ifdef ADDER_SCHED_TIMEOUT_EN
        return d > TO;
`else
        return 1'b0;
`endif
    endfunction

    task automatic cycle();
        logic [W-1:0] s;
        logic [N-1:0] exp_rdy;
        int           w;
        @(posedge clk);
        #1;
        cyc++;
        if (m_busy) m_age++;
        req_valid = stim_valid;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = stim_a[i];
            req_b[i*W +: W] = stim_b[i];
        end
        rsp_ready = stim_rdy;
        s = m_a + m_b;
        if (m_busy && m_age == 1 + m_delay && !exp_err(m_delay)) begin
            add_valid = 1'b1;
            add_y     = s;
        end else if (!m_busy || m_age == 1 || m_age >= rsp_start(m_delay)) begin
            add_valid = ($urandom_range(0, 3) == 0);
            add_y     = W'($urandom);
        end else begin
            add_valid = 1'b0;
            add_y     = W'($urandom);
        end

        @(negedge clk);
        if (!m_busy) begin
            w       = model_pick(stim_valid, m_last);
            exp_rdy = '0;
            if (w >= 0) exp_rdy[w] = 1'b1;
            chk("req_ready_idle", req_ready, exp_rdy);
            chk("rsp_valid_idle", rsp_valid, 0);
            chk("add_start_idle", add_start, 0);
            if (w >= 0) begin
                m_busy  = 1'b1;
                m_age   = 0;
                m_id    = w;
                m_a     = stim_a[w];
                m_b     = stim_b[w];
                m_delay = cur_delay;
                hs_cyc  = cyc;
                grants_q.push_back(w);
            end
        end else begin
            chk("req_ready_busy", req_ready, 0);
            chk("add_start", add_start, (m_age == 1));
            if (m_age < rsp_start(m_delay)) begin
                chk("add_a", add_a, m_a);
                chk("add_b", add_b, m_b);
                chk("rsp_valid_low", rsp_valid, 0);
            end else begin
                if (m_age == rsp_start(m_delay)) rsp_cyc = cyc;
                chk("rsp_valid", rsp_valid, 1);
                chk("rsp_id", rsp_id, m_id);
                chk("rsp_err", rsp_err, exp_err(m_delay));
                chk("rsp_y", rsp_y, exp_err(m_delay) ? '0 : s);
                if (stim_rdy) begin
                    last_y   = rsp_y;
                    last_id  = rsp_id;
                    last_err = rsp_err;
                    m_busy   = 1'b0;
                    m_last   = m_id;
                end
            end
        end
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        stim_valid = '0;
        stim_rdy   = 1'b1;
        while (m_busy && n < limit) begin
            cycle();
            n++;
        end
        if (m_busy) begin
            checks++;
            errors++;
            $display("FAIL wait_idle still busy after %0d cycles, want idle", limit);
        end
    endtask

    task automatic one_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input int d);
        stim_valid     = '0;
        stim_valid[id] = 1'b1;
        stim_a[id]     = a;
        stim_b[id]     = b;
        cur_delay      = d;
        stim_rdy       = 1'b1;
        cycle();
        wait_idle(40);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        rsp_ready  = 1'b0;
        add_y      = '0;
        add_valid  = 1'b0;
        stim_valid = '0;
        stim_rdy   = 1'b1;
        cur_delay  = 1;
        for (int i = 0; i < N; i++) begin
            stim_a[i] = '0;
            stim_b[i] = '0;
        end
        m_busy = 1'b0; m_age = 0; m_id = 0; m_last = N - 1; m_delay = 1;
        m_a = '0; m_b = '0; hs_cyc = 0; rsp_cyc = 0;
        last_y = '0; last_id = 0; last_err = 1'b0;

        #1;
        chk("reset_req_ready", req_ready, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_add_start", add_start, 0);
        chk("reset_rsp_y", rsp_y, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Rotation from reset with every requester valid.
        grants_q.delete();
        for (int i = 0; i < N; i++) begin
            stim_a[i] = W'(1000 * i + 7);
            stim_b[i] = W'(3 * i + 1);
        end
        stim_valid = '1;
        stim_rdy   = 1'b1;
        cur_delay  = 1;
        repeat (20) cycle();
        wait_idle(40);
        chk("rr_count", grants_q.size(), 5);
        if (grants_q.size() >= 5) begin
            chk("rr_g0", grants_q[0], 0);
            chk("rr_g1", grants_q[1], 1);
            chk("rr_g2", grants_q[2], 2);
            chk("rr_g3", grants_q[3], 3);
            chk("rr_g4", grants_q[4], 0);
        end

        // Single op with nominal latency.
        one_op(2, 20'd100, 20'd23, 1);
        chk("single_y", last_y, 123);
        chk("single_id", last_id, 2);
        chk("single_err", last_err, 0);
        chk("single_latency", rsp_cyc - hs_cyc, 3);

        // Backpressure in RESP while everyone else is requesting.
        stim_valid = 4'b0010;
        stim_a[1]  = 20'd55;
        stim_b[1]  = 20'd66;
        stim_rdy   = 1'b0;
        cycle();
        stim_valid = '1;
        repeat (7) cycle();
        stim_rdy = 1'b1;
        cycle();
        cycle();
        chk("bp_last_id", last_id, 1);
        chk("bp_last_y", last_y, 121);
        chk("bp_next_grant", grants_q[grants_q.size() - 1], 2);
        wait_idle(40);

        // Wrap-around of the sum.
        one_op(0, 20'hFFFFF, 20'd2, 1);
        chk("wrap_y", last_y, 1);
        chk("wrap_err", last_err, 0);

        // Randomized traffic with random adder delays and rsp backpressure.
        for (int n = 0; n < 1500; n++) begin
            stim_valid = N'($urandom);
            for (int i = 0; i < N; i++) begin
                stim_a[i] = W'($urandom);
                stim_b[i] = W'($urandom);
            end
            stim_rdy = ($urandom_range(0, 3) != 0);
`ifdef ADDER_SCHED_TIMEOUT_EN
            cur_delay = $urandom_range(1, 10);
`else
            cur_delay = $urandom_range(1, 3);
`endif
            cycle();
        end
        wait_idle(60);

`ifdef ADDER_SCHED_TIMEOUT_EN
        one_op(1, 20'd9, 20'd4, 100);
        chk("to_err", last_err, 1);
        chk("to_y", last_y, 0);
        chk("to_latency", rsp_cyc - hs_cyc, 10);
        one_op(3, 20'd9, 20'd4, TO);
        chk("to_edge_err", last_err, 0);
        chk("to_edge_y", last_y, 13);
`endif

        // Reset during WAIT with an adder that never answers.
        stim_valid = 4'b0001;
        stim_a[0]  = 20'd5;
        stim_b[0]  = 20'd6;
        cur_delay  = 100;
        cycle();
        stim_valid = '0;
`ifdef ADDER_SCHED_TIMEOUT_EN
        repeat (4) cycle();
`else
        repeat (20) cycle();
`endif
        chk("pre_reset_in_wait", m_busy && m_age >= 2, 1);
        #2;
        rst_n     = 1'b0;
        req_valid = 4'b1001;
        add_valid = 1'b0;
        #1;
        chk("mid_reset_req_ready", req_ready, 0);
        chk("mid_reset_rsp_valid", rsp_valid, 0);
        chk("mid_reset_rsp_id", rsp_id, 0);
        chk("mid_reset_rsp_y", rsp_y, 0);
        chk("mid_reset_rsp_err", rsp_err, 0);
        chk("mid_reset_add_start", add_start, 0);
        chk("mid_reset_add_a", add_a, 0);
        chk("mid_reset_add_b", add_b, 0);
        m_busy    = 1'b0;
        m_last    = N - 1;
        cur_delay = 1;
        repeat (2) @(negedge clk);
        req_valid = '0;
        rst_n     = 1'b1;
        stim_valid = 4'b1001;
        stim_a[3]  = 20'd40;
        stim_b[3]  = 20'd2;
        cycle();
        chk("post_reset_grant", grants_q[grants_q.size() - 1], 0);
        wait_idle(40);
        chk("post_reset_y", last_y, 11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
